// File: rtl/hazard_unit.sv
// Load-use stall, redirect flush and EX forwarding-select generation for the
// 5-stage RV32I pipeline, driven by a two-entry (EX, MEM) destination scoreboard.
module hazard_unit #(
  parameter logic [1:0] WBSEL_MEM = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_inst,
  input  logic        id_reg_wen,
  input  logic        id_rd_valid,
  input  logic [1:0]  id_wb_sel,
  input  logic        ex_redirect,
  output logic        stall,
  output logic        flush_id,
  output logic        bubble_ex,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  logic             ex_valid_q, ex_valid_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d;
  logic             ex_load_q, ex_load_d;
  logic             mem_valid_q;
  logic [REG_W-1:0] mem_rd_q;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic [REG_W-1:0] rs1, rs2, rd;
  logic             use_rs1, use_rs2;
  logic             ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic             load_use, writer, is_load;
  logic             unused_inst_bits;

  assign rs1 = id_inst[19:15];
  assign rs2 = id_inst[24:20];
  assign rd  = id_inst[11:7];
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:12]};

  // Source usage by opcode; non-32-bit encodings and unknown opcodes use nothing.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_inst[6:0])
      OPC_OP, OPC_BRANCH, OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign ex_hit_a  = use_rs1 && (rs1 != '0) && ex_valid_q  && (ex_rd_q  == rs1);
  assign ex_hit_b  = use_rs2 && (rs2 != '0) && ex_valid_q  && (ex_rd_q  == rs2);
  assign mem_hit_a = use_rs1 && (rs1 != '0) && mem_valid_q && (mem_rd_q == rs1);
  assign mem_hit_b = use_rs2 && (rs2 != '0) && mem_valid_q && (mem_rd_q == rs2);
  assign load_use  = ex_load_q && (ex_hit_a || ex_hit_b);

  assign writer  = id_reg_wen && id_rd_valid && (rd != '0);
  assign is_load = writer && (id_wb_sel == WBSEL_MEM);

  // A redirect discards the ID instruction, so it overrides any load-use stall.
  always_comb begin
    stall     = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    if (ex_redirect) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (load_use) begin
      stall     = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_comb begin
    ex_valid_d  = 1'b0;
    ex_rd_d     = rd;
    ex_load_d   = 1'b0;
    fwd_a_d     = FWD_RF;
    fwd_b_d     = FWD_RF;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bubble_ex) begin
      ex_valid_d = writer;
      ex_load_d  = is_load;
      // Youngest producer wins; an EX hit here is never a load (that would stall).
      if (ex_hit_a)       fwd_a_d = FWD_MEM;
      else if (mem_hit_a) fwd_a_d = FWD_WB;
      if (ex_hit_b)       fwd_b_d = FWD_MEM;
      else if (mem_hit_b) fwd_b_d = FWD_WB;
    end
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ex_redirect && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      mem_valid_q <= ex_valid_q;
      mem_rd_q    <= ex_rd_q;
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_load_q   <= ex_load_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
